// File: rtl/alarm_tone_sequencer.sv
// ============================================================================
//  Module   : alarm_tone_sequencer
//  Brief    : Fixed-priority scheduler for six alarm tone patterns driving one
//             square-wave oscillator and the audio-out FIFO write path.
//             Optional preemption: define ALARM_TONE_SEQUENCER_PREEMPT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_tone_sequencer #(
    parameter int STEP_CYCLES = 7500000,
    parameter int GAP_CYCLES  = 7500000,
    parameter int AMP_HI      = 10000000,
    parameter int AMP_LO      = 6000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  req,
    input  logic        sound_off,
    input  logic        sound_vol,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] sample_out,
    output logic        busy,
    output logic [2:0]  grant_id,
    output logic [2:0]  step,
    output logic        tone_on,
    output logic [18:0] tone_half_period
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [31:0]        c_STEP_LAST = 32'(STEP_CYCLES - 1);
    localparam logic [31:0]        c_GAP_LAST  = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic signed [31:0] c_AMP_HI    = 32'(AMP_HI);
    localparam logic signed [31:0] c_AMP_LO    = 32'(AMP_LO);
    localparam logic [14:0]        c_HP_LOW    = 15'h0BB8;

    state_t             r_state;
    logic [31:0]        r_step_cnt;
    logic [31:0]        r_gap_cnt;
    logic [18:0]        r_osc_cnt;
    logic               r_phase;
    logic signed [31:0] r_sample;

    logic               w_req_any;
    logic [2:0]         w_pick;
    logic [4:0]         w_pick_entry;
    logic [4:0]         w_next_entry;
    logic               w_step_end;
    logic               w_gap_end;
    logic signed [31:0] w_amp;

    // Lower rank = higher priority: 5 > 2 > 0 > 3 > 1 > 4
    function automatic logic [2:0] f_rank(input logic [2:0] id);
        case (id)
            3'd5:    f_rank = 3'd0;
            3'd2:    f_rank = 3'd1;
            3'd0:    f_rank = 3'd2;
            3'd3:    f_rank = 3'd3;
            3'd1:    f_rank = 3'd4;
            default: f_rank = 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] f_pick(input logic [5:0] r);
        if (r[5])      f_pick = 3'd5;
        else if (r[2]) f_pick = 3'd2;
        else if (r[0]) f_pick = 3'd0;
        else if (r[3]) f_pick = 3'd3;
        else if (r[1]) f_pick = 3'd1;
        else           f_pick = 3'd4;
    endfunction

    // Returns {note code, on bit}; codes packed with step 0 in the LSBs,
    // on bits written step 0 first (MSB).
    function automatic logic [4:0] f_entry(input logic [2:0] id, input logic [2:0] st);
        logic [31:0] codes;
        logic [7:0]  ons;
        case (id)
            3'd5: begin
                codes = {4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
                ons   = 8'b11111111;
            end
            3'd2: begin
                codes = {4'd11, 4'd11, 4'd11, 4'd11, 4'd5, 4'd7, 4'd9, 4'd11};
                ons   = 8'b11110000;
            end
            3'd0: begin
                codes = {4'd9, 4'd9, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2, 4'd2};
                ons   = 8'b11101000;
            end
            3'd3: begin
                codes = {4'd12, 4'd12, 4'd9, 4'd9, 4'd12, 4'd8, 4'd12, 4'd8};
                ons   = 8'b10001110;
            end
            3'd1: begin
                codes = {4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd3, 4'd3};
                ons   = 8'b11000000;
            end
            default: begin
                codes = {4'd14, 4'd14, 4'd14, 4'd14, 4'd14, 4'd14, 4'd13, 4'd13};
                ons   = 8'b11000000;
            end
        endcase
        f_entry = {codes[{st, 2'b00} +: 4], ons[3'd7 - st]};
    endfunction

    assign w_req_any       = |req;
    assign w_pick          = f_pick(req);
    assign w_pick_entry    = f_entry(w_pick, 3'd0);
    assign w_next_entry    = f_entry(grant_id, 3'(step + 3'd1));
    assign w_step_end      = (r_step_cnt == c_STEP_LAST);
    assign w_gap_end       = (r_gap_cnt == c_GAP_LAST);
    assign w_amp           = sound_vol ? c_AMP_HI : c_AMP_LO;
    assign write_audio_out = audio_out_allowed;
    assign sample_out      = r_sample;

`ifdef ALARM_TONE_SEQUENCER_PREEMPT_EN
    logic [5:0] w_higher;
    logic       w_preempt;
    logic [2:0] w_pre_id;
    logic [4:0] w_pre_entry;

    always_comb begin
        w_higher = '0;
        for (int j = 0; j < 6; j++) begin
            w_higher[j] = req[j] && (f_rank(3'(j)) < f_rank(grant_id));
        end
    end

    assign w_preempt   = |w_higher;
    assign w_pre_id    = f_pick(w_higher);
    assign w_pre_entry = f_entry(w_pre_id, 3'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            busy             <= 1'b0;
            grant_id         <= 3'd0;
            step             <= 3'd0;
            tone_on          <= 1'b0;
            tone_half_period <= '0;
            r_phase          <= 1'b0;
            r_step_cnt       <= '0;
            r_gap_cnt        <= '0;
            r_osc_cnt        <= '0;
            r_sample         <= '0;
        end else begin
            if (sound_off || !tone_on || !busy)
                r_sample <= '0;
            else
                r_sample <= r_phase ? w_amp : -w_amp;

            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_state          <= ST_PLAY;
                        busy             <= 1'b1;
                        grant_id         <= w_pick;
                        step             <= 3'd0;
                        tone_on          <= w_pick_entry[0];
                        tone_half_period <= {w_pick_entry[4:1], c_HP_LOW};
                        r_step_cnt       <= '0;
                        r_osc_cnt        <= '0;
                        r_phase          <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (w_step_end) begin
                        r_step_cnt <= '0;
                        r_osc_cnt  <= '0;
                        r_phase    <= 1'b0;
`ifdef ALARM_TONE_SEQUENCER_PREEMPT_EN
                        if (w_preempt) begin
                            grant_id         <= w_pre_id;
                            step             <= 3'd0;
                            tone_on          <= w_pre_entry[0];
                            tone_half_period <= {w_pre_entry[4:1], c_HP_LOW};
                        end else
`endif
                        if (step == 3'd7) begin
                            if (GAP_CYCLES > 0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= '0;
                                tone_on   <= 1'b0;
                            end else if (w_req_any) begin
                                grant_id         <= w_pick;
                                step             <= 3'd0;
                                tone_on          <= w_pick_entry[0];
                                tone_half_period <= {w_pick_entry[4:1], c_HP_LOW};
                            end else begin
                                r_state          <= ST_IDLE;
                                busy             <= 1'b0;
                                step             <= 3'd0;
                                tone_on          <= 1'b0;
                                tone_half_period <= '0;
                            end
                        end else begin
                            step             <= 3'(step + 3'd1);
                            tone_on          <= w_next_entry[0];
                            tone_half_period <= {w_next_entry[4:1], c_HP_LOW};
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + 32'd1;
                        if (r_osc_cnt == tone_half_period) begin
                            r_osc_cnt <= '0;
                            r_phase   <= ~r_phase;
                        end else begin
                            r_osc_cnt <= r_osc_cnt + 19'd1;
                        end
                    end
                end

                ST_GAP: begin
                    if (w_gap_end) begin
                        r_gap_cnt <= '0;
                        if (w_req_any) begin
                            r_state          <= ST_PLAY;
                            grant_id         <= w_pick;
                            step             <= 3'd0;
                            tone_on          <= w_pick_entry[0];
                            tone_half_period <= {w_pick_entry[4:1], c_HP_LOW};
                            r_step_cnt       <= '0;
                            r_osc_cnt        <= '0;
                            r_phase          <= 1'b0;
                        end else begin
                            r_state          <= ST_IDLE;
                            busy             <= 1'b0;
                            step             <= 3'd0;
                            tone_half_period <= '0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alarm_tone_sequencer.sv
// ============================================================================
//  Module   : tb_alarm_tone_sequencer
//  Brief    : Directed self-checking bench for alarm_tone_sequencer
//             (STEP_CYCLES=16, GAP_CYCLES=8, AMP_HI=100, AMP_LO=60).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_tone_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  req;
    logic        sound_off;
    logic        sound_vol;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] sample_out;
    logic        busy;
    logic [2:0]  grant_id;
    logic [2:0]  step;
    logic        tone_on;
    logic [18:0] tone_half_period;

    int checks = 0;
    int errors = 0;

    alarm_tone_sequencer #(
        .STEP_CYCLES(16),
        .GAP_CYCLES (8),
        .AMP_HI     (100),
        .AMP_LO     (60)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .sound_off        (sound_off),
        .sound_vol        (sound_vol),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out  (write_audio_out),
        .sample_out       (sample_out),
        .busy             (busy),
        .grant_id         (grant_id),
        .step             (step),
        .tone_on          (tone_on),
        .tone_half_period (tone_half_period)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_step"},  32'(step), 32'd0);
        chk({tag, "_tone"},  32'(tone_on), 32'd0);
        chk({tag, "_thp"},   32'(tone_half_period), 32'd0);
        chk({tag, "_samp"},  sample_out, 32'd0);
    endtask

    // id0 pattern, hand-expanded: codes 2,2,3,7,4,9,9,9 ; on 1,1,1,0,1,0,0,0
    logic [18:0] exp_thp_id0 [8] = '{19'h10BB8, 19'h10BB8, 19'h18BB8, 19'h38BB8,
                                     19'h20BB8, 19'h48BB8, 19'h48BB8, 19'h48BB8};
    logic        exp_on_id0  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset             = 1'b1;
        req               = 6'd0;
        sound_off         = 1'b0;
        sound_vol         = 1'b1;
        audio_out_allowed = 1'b0;
        tick(2);
        chk_reset_state("rst");
        reset = 1'b0;

        // Idle: silence streamed, write strobe follows the FIFO-space flag
        for (int i = 0; i < 4; i++) begin
            audio_out_allowed = i[0];
            tick(50);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_samp", sample_out, 32'd0);
            chk("idle_wr", 32'(write_audio_out), 32'(i[0]));
        end
        audio_out_allowed = 1'b1;

        // Single-cycle request from hunger (id0): full pattern then gap
        req = 6'b000001;
        tick(1);
        req = 6'd0;
        chk("p0_busy", 32'(busy), 32'd1);
        chk("p0_grant", 32'(grant_id), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("p0_step", 32'(step), 32'(k));
            chk("p0_tone", 32'(tone_on), 32'(exp_on_id0[k]));
            chk("p0_thp", 32'(tone_half_period), 32'(exp_thp_id0[k]));
            if (k == 0) begin
                tick(1);
                chk("p0_samp_neg", sample_out, -32'sd100);
                tick(15);
            end else begin
                tick(16);
            end
        end
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_tone", 32'(tone_on), 32'd0);
        tick(7);
        chk("gap_end_busy", 32'(busy), 32'd1);
        tick(1);
        chk("after_gap_busy", 32'(busy), 32'd0);

        // Held requests 5,2,0: re-grant to 5, then 2 after bit5 drops
        req = 6'b100101;
        tick(1);
        chk("h_grant5", 32'(grant_id), 32'd5);
        chk("h_thp5", 32'(tone_half_period), 32'h18BB8);
        tick(136);
        chk("h_regrant5", 32'(grant_id), 32'd5);
        chk("h_regrant_step", 32'(step), 32'd0);
        chk("h_regrant_busy", 32'(busy), 32'd1);
        tick(40);
        req = 6'b000101;
        tick(95);
        chk("h_latched5", 32'(grant_id), 32'd5);
        chk("h_in_gap_tone", 32'(tone_on), 32'd0);
        tick(1);
        chk("h_grant2", 32'(grant_id), 32'd2);
        chk("h_step2", 32'(step), 32'd0);
        chk("h_thp2", 32'(tone_half_period), 32'h58BB8);
        req = 6'd0;

        // Amplitude, volume and mute on the dying pattern
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req   = 6'b100000;
        tick(1);
        req = 6'd0;
        tick(1);
        chk("amp_hi", sample_out, -32'sd100);
        sound_vol = 1'b0;
        tick(1);
        chk("amp_lo", sample_out, -32'sd60);
        sound_off = 1'b1;
        tick(1);
        chk("mute_samp", sample_out, 32'd0);
        tick(16);
        chk("mute_step", 32'(step), 32'd1);
        chk("mute_tone", 32'(tone_on), 32'd1);
        chk("mute_samp2", sample_out, 32'd0);
        sound_off = 1'b0;
        sound_vol = 1'b1;

        // Reset at step 4, cycle 7 of a dirty (id3) pattern
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req   = 6'b001000;
        tick(1);
        req = 6'd0;
        chk("r_grant3", 32'(grant_id), 32'd3);
        chk("r_thp3", 32'(tone_half_period), 32'h40BB8);
        tick(71);
        chk("r_step4", 32'(step), 32'd4);
        reset = 1'b1;
        tick(1);
        chk_reset_state("midrst");
        reset = 1'b0;
        req   = 6'b001000;
        tick(1);
        req = 6'd0;
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_step", 32'(step), 32'd0);
        chk("rs_grant", 32'(grant_id), 32'd3);

        // Higher-priority request arriving during a bored (id1) pattern
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req   = 6'b000010;
        tick(1);
        req = 6'd0;
        chk("pe_grant1", 32'(grant_id), 32'd1);
        tick(34);
        chk("pe_step2", 32'(step), 32'd2);
        req = 6'b100000;
        tick(13);
        chk("pe_hold_grant", 32'(grant_id), 32'd1);
        chk("pe_hold_step", 32'(step), 32'd2);
        tick(1);
`ifdef ALARM_TONE_SEQUENCER_PREEMPT_EN
        chk("pe_grant5", 32'(grant_id), 32'd5);
        chk("pe_step0", 32'(step), 32'd0);
        chk("pe_thp5", 32'(tone_half_period), 32'h18BB8);
`else
        chk("np_grant1", 32'(grant_id), 32'd1);
        chk("np_step3", 32'(step), 32'd3);
        tick(64);
        chk("np_grant1_s7", 32'(grant_id), 32'd1);
        chk("np_step7", 32'(step), 32'd7);
`endif
        req = 6'd0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
